// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the Dec/Ex hazard controller.
// Holds the FSM state encodings, the register-index width default and a counter sizing helper.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W_DEF = 8;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_LDUSE = 2'd1;
    localparam logic [1:0] ST_DIVW  = 2'd2;
    localparam logic [1:0] ST_REDIR = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hz_countdown.sv
// Loadable down-counter shared by the LDUSE, DIVW and REDIR sequences.
// A load wins over a decrement, and the count holds at zero.
module hz_countdown #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / bubble / flush sequencer for the fetch, decode and Dec/Ex pipeline registers.
// Hazard compare, priority mux and FSM; outputs are Mealy and same-cycle with detection.
//
//  state | meaning
//  RUN   | no sequence active; evaluate redirect > divide > load-use
//  LDUSE | extra load-use bubbles (LOAD_LAT > 1)
//  DIVW  | divider still occupying EX, everything frozen
//  REDIR | extra squash cycles after a redirect (FLUSH_CYCLES > 1)
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int DIV_CYCLES   = 16,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_a_reg,
    input  logic [REG_W-1:0] dec_b_reg,
    input  logic             dec_uses_a,
    input  logic             dec_uses_b,
    input  logic             ex_mem,
    input  logic             ex_store,
    input  logic             ex_rwe,
    input  logic [REG_W-1:0] ex_c_reg,
    input  logic             ex_div,
    input  logic             ex_redirect,
    output logic             stall_fd,
    output logic             stall_de,
    output logic             bubble_de,
    output logic             flush_fd,
    output logic             div_busy
);

    localparam int CW = $clog2(max3(DIV_CYCLES, LOAD_LAT, FLUSH_CYCLES) + 1);

    localparam logic [CW-1:0] DIV_LD   = CW'((DIV_CYCLES   > 1) ? DIV_CYCLES   - 2 : 0);
    localparam logic [CW-1:0] LOAD_LD  = CW'((LOAD_LAT     > 1) ? LOAD_LAT     - 2 : 0);
    localparam logic [CW-1:0] FLUSH_LD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_lu;
    logic          w_load;
    logic          w_dec;
    logic [CW-1:0] w_load_val;
    logic          w_zero;
    logic          w_stall_fd;
    logic          w_stall_de;
    logic          w_bubble_de;
    logic          w_flush_fd;
    logic          w_div_busy;

    assign w_lu = ex_mem & ~ex_store & ex_rwe & dec_valid
                & ((dec_uses_a & (dec_a_reg == ex_c_reg))
                 | (dec_uses_b & (dec_b_reg == ex_c_reg)));

    hz_countdown #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_dec  (w_dec),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_load_val  = '0;
        w_stall_fd  = 1'b0;
        w_stall_de  = 1'b0;
        w_bubble_de = 1'b0;
        w_flush_fd  = 1'b0;
        w_div_busy  = 1'b0;
        case (r_state)
            ST_RUN, ST_LDUSE: begin
                // A redirect pre-empts an in-flight load-use sequence as well.
                if (ex_redirect) begin
                    w_flush_fd  = 1'b1;
                    w_bubble_de = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_REDIR;
                        w_load      = 1'b1;
                        w_load_val  = FLUSH_LD;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (r_state == ST_LDUSE) begin
                    w_stall_fd  = 1'b1;
                    w_bubble_de = 1'b1;
                    if (w_zero) w_state_nxt = ST_RUN;
                    else        w_dec       = 1'b1;
                end else if (ex_div) begin
                    w_stall_fd = 1'b1;
                    w_stall_de = 1'b1;
                    w_div_busy = 1'b1;
                    if (DIV_CYCLES > 1) begin
                        w_state_nxt = ST_DIVW;
                        w_load      = 1'b1;
                        w_load_val  = DIV_LD;
                    end
                end else if (w_lu) begin
                    w_stall_fd  = 1'b1;
                    w_bubble_de = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_state_nxt = ST_LDUSE;
                        w_load      = 1'b1;
                        w_load_val  = LOAD_LD;
                    end
                end
            end
            ST_DIVW: begin
                w_stall_fd = 1'b1;
                w_stall_de = 1'b1;
                w_div_busy = 1'b1;
                if (w_zero) w_state_nxt = ST_RUN;
                else        w_dec       = 1'b1;
            end
            ST_REDIR: begin
                w_flush_fd  = 1'b1;
                w_bubble_de = 1'b1;
                if (ex_redirect) begin
                    w_load     = 1'b1;
                    w_load_val = FLUSH_LD;
                end else if (w_zero) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Outputs are combinational, so force them low for the whole reset window.
    assign stall_fd  = w_stall_fd  & rst_n;
    assign stall_de  = w_stall_de  & rst_n;
    assign bubble_de = w_bubble_de & rst_n;
    assign flush_fd  = w_flush_fd  & rst_n;
    assign div_busy  = w_div_busy  & rst_n;

endmodule
